// File: rtl/chip_select_memory.sv
// Chip-selected single-port word memory with READ_LATENCY-deep read pipeline; accepts one request per cycle once READY.
// Optional power-on clear sweep of every index is compiled in with CHIP_SELECT_MEMORY_CLEAR_EN.
module chip_select_memory #(
  parameter int   DATA_WIDTH   = 27,
  parameter int   ADDR_WIDTH   = 14,
  parameter logic CHIP_SELECT  = 1'b1,
  parameter int   READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  req_ready,
  output logic                  read_valid,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  busy
);

  localparam int IDX_W = ADDR_WIDTH - 1;
  localparam int DEPTH = 1 << IDX_W;

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("chip_select_memory: READ_LATENCY must be in 1..4");
    end
  endgenerate

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

`ifdef CHIP_SELECT_MEMORY_CLEAR_EN
  localparam state_t RESET_STATE = ST_CLEAR;
`else
  localparam state_t RESET_STATE = ST_READY;
`endif

  state_t r_state;
  state_t w_state_nxt;
  // Low during reset and for the first edge after release, so outputs stay quiet until then.
  logic   r_live;

`ifdef CHIP_SELECT_MEMORY_CLEAR_EN
  logic [IDX_W-1:0] r_clr_idx;
  logic [IDX_W-1:0] w_clr_idx_nxt;
  logic             w_clr_we;
`endif

  logic [IDX_W-1:0] w_idx;
  logic             w_sel;
  logic             w_accept;
  logic             w_wr_fire;
  logic             w_rd_fire;

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [READ_LATENCY-1:0] r_pipe_vld;
  logic [DATA_WIDTH-1:0]   r_pipe_dat [READ_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RESET_STATE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
    end
  end

`ifdef CHIP_SELECT_MEMORY_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_idx <= '0;
    end else begin
      r_clr_idx <= w_clr_idx_nxt;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    busy        = 1'b0;
`ifdef CHIP_SELECT_MEMORY_CLEAR_EN
    w_clr_idx_nxt = r_clr_idx;
    w_clr_we      = 1'b0;
`endif
    case (r_state)
      ST_CLEAR: begin
`ifdef CHIP_SELECT_MEMORY_CLEAR_EN
        if (r_live) begin
          busy          = 1'b1;
          w_clr_we      = 1'b1;
          w_clr_idx_nxt = r_clr_idx + 1'b1;
          if (r_clr_idx == {IDX_W{1'b1}}) begin
            w_state_nxt = ST_READY;
          end
        end
`else
        w_state_nxt = ST_READY;
`endif
      end
      ST_READY: begin
        req_ready = r_live;
      end
      default: begin
        w_state_nxt = RESET_STATE;
      end
    endcase
  end

  assign w_idx     = address[IDX_W-1:0];
  assign w_sel     = (address[ADDR_WIDTH-1] == CHIP_SELECT);
  // rst_n in the accept term keeps a write coincident with reset assertion from landing.
  assign w_accept  = req_valid & req_ready & rst_n;
  assign w_wr_fire = w_accept & w_sel & req_write;
  assign w_rd_fire = w_accept & w_sel & ~req_write;

  always_ff @(posedge clk) begin
`ifdef CHIP_SELECT_MEMORY_CLEAR_EN
    if (w_clr_we) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_wr_fire) begin
      r_mem[w_idx] <= write_data;
    end
`else
    if (w_wr_fire) begin
      r_mem[w_idx] <= write_data;
    end
`endif
  end

  // Data lanes advance only behind a valid bit, so the last stage holds between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_pipe_dat[i] <= '0;
      end
    end else begin
      r_pipe_vld[0] <= w_rd_fire;
      if (w_rd_fire) begin
        r_pipe_dat[0] <= r_mem[w_idx];
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        if (r_pipe_vld[i-1]) begin
          r_pipe_dat[i] <= r_pipe_dat[i-1];
        end
      end
    end
  end

  assign read_valid = r_pipe_vld[READ_LATENCY-1];
  assign read_data  = r_pipe_dat[READ_LATENCY-1];

endmodule

// File: tb/tb_chip_select_memory.sv
// Bench for chip_select_memory: a default instance (latency 1) and a small latency-3 instance,
// with a scoreboard of expected read words and their due cycles.
module tb_chip_select_memory;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        a_rst_n, a_vld, a_wr, a_rdy, a_rv, a_busy;
  logic [13:0] a_addr;
  logic [26:0] a_wdat, a_rd;
  logic        b_rst_n, b_vld, b_wr, b_rdy, b_rv, b_busy;
  logic [4:0]  b_addr;
  logic [26:0] b_wdat, b_rd;

  typedef struct {
    logic [26:0] dat;
    int          cyc;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  chip_select_memory u_dut_a (
    .clk(clk), .rst_n(a_rst_n), .req_valid(a_vld), .req_write(a_wr), .address(a_addr),
    .write_data(a_wdat), .req_ready(a_rdy), .read_valid(a_rv), .read_data(a_rd), .busy(a_busy)
  );

  chip_select_memory #(.DATA_WIDTH(27), .ADDR_WIDTH(5), .CHIP_SELECT(1'b1), .READ_LATENCY(3)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n), .req_valid(b_vld), .req_write(b_wr), .address(b_addr),
    .write_data(b_wdat), .req_ready(b_rdy), .read_valid(b_rv), .read_data(b_rd), .busy(b_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Drive one request cycle; for reads, dat is the expected word and push queues it.
  task automatic drv(input bit to_b, input bit vld, input bit wr, input logic [13:0] addr,
                     input logic [26:0] dat, input bit push);
    @(posedge clk); #1;
    a_vld = 1'b0;
    b_vld = 1'b0;
    if (to_b) begin
      b_vld = vld; b_wr = wr; b_addr = addr[4:0]; b_wdat = dat;
      if (push) qb.push_back('{dat, cyc + 3});
      if (vld) chk("b_req_ready", b_rdy, 1);
    end else begin
      a_vld = vld; a_wr = wr; a_addr = addr; a_wdat = dat;
      if (push) qa.push_back('{dat, cyc + 1});
      if (vld) chk("a_req_ready", a_rdy, 1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 1'b0, 14'h0, 27'h0, 1'b0);
  endtask

  task automatic wait_rdy(input bit to_b, input int max);
    for (int i = 0; i < max; i++) begin
      if (to_b ? b_rdy : a_rdy) break;
      @(posedge clk); #1;
    end
    chk(to_b ? "b_ready_timeout" : "a_ready_timeout", to_b ? b_rdy : a_rdy, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_rv) begin
      if (qa.size() == 0) chk("a_unexpected_strobe", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_read_data", a_rd, e.dat);
        chk("a_read_cycle", cyc, e.cyc);
      end
    end
    if (b_rv) begin
      if (qb.size() == 0) chk("b_unexpected_strobe", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_read_data", b_rd, e.dat);
        chk("b_read_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    a_rst_n = 1'b0; a_vld = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdat = '0;
    b_rst_n = 1'b0; b_vld = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdat = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("a_rst_ready", a_rdy, 0);
    chk("a_rst_valid", a_rv, 0);
    chk("a_rst_data", a_rd, 0);
    chk("a_rst_busy", a_busy, 0);
    chk("b_rst_ready", b_rdy, 0);
    chk("b_rst_valid", b_rv, 0);
    chk("b_rst_data", b_rd, 0);
    chk("b_rst_busy", b_busy, 0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
`ifndef CHIP_SELECT_MEMORY_CLEAR_EN
    @(posedge clk); #1;
    chk("a_ready_first_edge", a_rdy, 1);
    chk("b_ready_first_edge", b_rdy, 1);
    chk("a_busy_tied", a_busy, 0);
    chk("b_busy_tied", b_busy, 0);
`else
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      chk("b_sweep_busy", b_busy, 1);
      chk("b_sweep_ready", b_rdy, 0);
    end
    @(posedge clk); #1;
    chk("b_sweep_done_busy", b_busy, 0);
    chk("b_sweep_done_ready", b_rdy, 1);
    wait_rdy(1'b0, 9000);
`endif

    // Latency-1 write then read-after-write.
    drv(0, 1, 1, 14'h2000, 27'h2800010, 0);
    drv(0, 1, 0, 14'h2000, 27'h2800010, 1);
    idle(1);
    // Unselected write must not touch index 5; unselected read must not strobe.
    drv(0, 1, 1, 14'h2005, 27'h0123456, 0);
    drv(0, 1, 1, 14'h0005, 27'h7FFFFFF, 0);
    drv(0, 1, 0, 14'h2005, 27'h0123456, 1);
    drv(0, 1, 0, 14'h0005, 27'h0, 0);
    idle(3);
    // Top index and back-to-back reads.
    drv(0, 1, 1, 14'h3FFF, 27'h5A5A5A5, 0);
    drv(0, 1, 1, 14'h2100, 27'h1234567, 0);
    drv(0, 1, 0, 14'h3FFF, 27'h5A5A5A5, 1);
    drv(0, 1, 0, 14'h2100, 27'h1234567, 1);
    drv(0, 1, 0, 14'h2000, 27'h2800010, 1);
    idle(1);
    // Hold after strobe.
    drv(0, 1, 1, 14'h2010, 27'h0880100, 0);
    drv(0, 1, 0, 14'h2010, 27'h0880100, 1);
    idle(1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("a_hold_data", a_rd, 27'h0880100);
      chk("a_hold_valid", a_rv, 0);
    end

    // Latency-3 instance: consecutive reads.
    drv(1, 1, 1, 14'h11, 27'h11, 0);
    drv(1, 1, 1, 14'h12, 27'h22, 0);
    drv(1, 1, 1, 14'h13, 27'h33, 0);
    drv(1, 1, 0, 14'h11, 27'h11, 1);
    drv(1, 1, 0, 14'h12, 27'h22, 1);
    drv(1, 1, 0, 14'h13, 27'h33, 1);
    drv(1, 1, 1, 14'h03, 27'h7FFFFFF, 0);
    drv(1, 1, 0, 14'h13, 27'h33, 1);
    idle(5);

    // Reset one cycle after a read is accepted: the read must never strobe.
    drv(1, 1, 0, 14'h11, 27'h0, 0);
    @(posedge clk); #1;
    b_vld = 1'b0;
    b_rst_n = 1'b0;
    #1;
    chk("b_midrst_valid", b_rv, 0);
    chk("b_midrst_data", b_rd, 0);
    chk("b_midrst_ready", b_rdy, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("b_inrst_ready", b_rdy, 0);
      chk("b_inrst_valid", b_rv, 0);
    end
    b_rst_n = 1'b1;
    wait_rdy(1'b1, 40);
`ifndef CHIP_SELECT_MEMORY_CLEAR_EN
    drv(1, 1, 0, 14'h12, 27'h22, 1);
`else
    for (int i = 0; i < 16; i++) begin
      logic [13:0] ad;
      ad = 14'h10 | 14'(i);
      drv(1, 1, 0, ad, 27'h0, 1);
    end
`endif
    idle(6);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
